// File: rtl/switch_decoder_db.sv
// Switch bank front end: synchronises a raw bouncing switch vector and
// debounces it as a whole word. It then drives a registered LED vector in one
// of four decode modes. The accepted code and a one-cycle change strobe are
// exported for downstream logic.
module switch_decoder_db #(
    parameter int SW_W            = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    localparam int LED_W          = 2 ** SW_W,
    localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SW_W-1:0]  sw,
    input  logic [1:0]       mode,
    output logic [LED_W-1:0] led,
    output logic [SW_W-1:0]  code,
    output logic             changed
);

    // Decode mode encodings
    localparam logic [1:0] MODE_ONE_HOT = 2'd0;
    localparam logic [1:0] MODE_THERMO  = 2'd1;
    localparam logic [1:0] MODE_PASS    = 2'd2;
    localparam logic [1:0] MODE_BLANK   = 2'd3;

    // Counter value meaning "candidate has been stable long enough"
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // LED pattern for a given code and mode. The thermometer pattern is
    // derived from the one-hot pattern: (1 << c) - 1 sets every bit below c.
    // For the top code it therefore leaves only the MSB clear.
    function automatic logic [LED_W-1:0] decode_led(
        input logic [SW_W-1:0] c,
        input logic [1:0]      m
    );
        logic [LED_W-1:0] one_hot;
        logic [LED_W-1:0] result;
        one_hot = {{(LED_W-1){1'b0}}, 1'b1} << c;
        case (m)
            MODE_ONE_HOT: result = one_hot;
            MODE_THERMO:  result = one_hot - {{(LED_W-1){1'b0}}, 1'b1};
            MODE_PASS:    result = {{(LED_W-SW_W){1'b0}}, c};
            MODE_BLANK:   result = {LED_W{1'b0}};
            default:      result = {LED_W{1'b0}};
        endcase
        return result;
    endfunction

    // Synchroniser stages
    logic [SW_W-1:0]  sync1_r;
    logic [SW_W-1:0]  sync2_r;

    // Debounce state
    logic [SW_W-1:0]  cand_r;
    logic [CNT_W-1:0] cnt_r;

    // Output registers
    logic [SW_W-1:0]  code_r;
    logic [LED_W-1:0] led_r;
    logic             changed_r;

    // Next-state values
    logic [SW_W-1:0]  cand_next_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic             accept_s;
    logic [SW_W-1:0]  code_next_s;
    logic [LED_W-1:0] led_next_s;

    // Two-flop synchroniser for the asynchronous switch pins
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= {SW_W{1'b0}};
            sync2_r <= {SW_W{1'b0}};
        end else begin
            sync1_r <= sw;
            sync2_r <= sync1_r;
        end
    end

    // Candidate tracking: a new synchronised value restarts the stability count.
    // An unchanged value counts up and then saturates, so it never wraps.
    always_comb begin
        cand_next_s = cand_r;
        cnt_next_s  = cnt_r;
        if (sync2_r != cand_r) begin
            cand_next_s = sync2_r;
            cnt_next_s  = {CNT_W{1'b0}};
        end else if (cnt_r < CNT_MAX) begin
            cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Acceptance: the candidate must still be stable, fully counted, and new.
    // A glitch that settles back on the current code therefore never strobes.
    always_comb begin
        accept_s    = (sync2_r == cand_r) && (cnt_r == CNT_MAX) && (cand_r != code_r);
        code_next_s = code_r;
        if (accept_s) begin
            code_next_s = cand_r;
        end else begin
            code_next_s = code_r;
        end
        led_next_s = decode_led(code_next_s, mode);
    end

    // Debounce state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_r <= {SW_W{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
        end else begin
            cand_r <= cand_next_s;
            cnt_r  <= cnt_next_s;
        end
    end

    // Output registers: led follows the code value being loaded on this edge
    always_ff @(posedge clk) begin
        if (rst) begin
            code_r    <= {SW_W{1'b0}};
            led_r     <= {LED_W{1'b0}};
            changed_r <= 1'b0;
        end else begin
            code_r    <= code_next_s;
            led_r     <= led_next_s;
            changed_r <= accept_s;
        end
    end

    assign code    = code_r;
    assign led     = led_r;
    assign changed = changed_r;

endmodule

// File: tb/tb_switch_decoder_db.sv
// Self-checking bench for switch_decoder_db (SW_W=4, DEBOUNCE_CYCLES=4).
// Every edge is compared against a sample-history reference model. The
// directed sequences also carry explicit constant expectations.
module tb_switch_decoder_db;

    localparam int SW_W  = 4;
    localparam int DB    = 4;
    localparam int LED_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [SW_W-1:0]  sw;
    logic [1:0]       mode;
    logic [LED_W-1:0] led;
    logic [SW_W-1:0]  code;
    logic             changed;

    int total = 0;
    int bad   = 0;

    // Reference model state
    // hist[k] holds the sw value sampled k+1 edges ago.
    int hist [DB+2];
    int m_code;
    int m_led;
    int m_changed;

    typedef struct {
        int sw_v;
        int mode_v;
        int exp_led;
        int exp_pulses;
    } vec_t;

    vec_t tbl [8];

    switch_decoder_db #(
        .SW_W(SW_W),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw(sw),
        .mode(mode),
        .led(led),
        .code(code),
        .changed(changed)
    );

    always #5 clk = ~clk;

    function automatic int ref_led(input int c, input int m);
        case (m)
            0:       return 2 ** c;
            1:       return (2 ** c) - 1;
            2:       return c;
            default: return 0;
        endcase
    endfunction

    // A value is accepted once the samples taken 2..DB+2 edges ago all agree
    // on it, provided it differs from the code currently held.
    task automatic model_edge(input int s, input int m, input bit r);
        bit steady;
        if (r) begin
            for (int k = 0; k < DB + 2; k++) hist[k] = 0;
            m_code    = 0;
            m_led     = 0;
            m_changed = 0;
        end else begin
            steady = 1'b1;
            for (int k = 2; k <= DB + 1; k++)
                if (hist[k] != hist[1]) steady = 1'b0;
            m_changed = 0;
            if (steady && hist[1] != m_code) begin
                m_code    = hist[1];
                m_changed = 1;
            end
            m_led = ref_led(m_code, m);
            for (int k = DB + 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = s;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs for one edge, advance the model, compare all outputs
    task automatic step(input int s, input int m, input bit r);
        sw   = 4'(s);
        mode = 2'(m);
        rst  = r;
        @(posedge clk);
        model_edge(s, m, r);
        #1;
        chk("model_code", int'(code), m_code);
        chk("model_led", int'(led), m_led);
        chk("model_changed", int'(changed), m_changed);
    endtask

    initial begin
        int  pulses;
        int  pulse_at;
        bit  same;
        int  v;
        int  hold;
        int  m;

        tbl[0] = '{9, 0, 32'h0200, 1};
        tbl[1] = '{9, 1, 32'h01FF, 0};
        tbl[2] = '{9, 2, 32'h0009, 0};
        tbl[3] = '{9, 3, 32'h0000, 0};
        tbl[4] = '{15, 0, 32'h8000, 1};
        tbl[5] = '{15, 1, 32'h7FFF, 0};
        tbl[6] = '{0, 1, 32'h0000, 1};
        tbl[7] = '{0, 0, 32'h0001, 0};

        for (int k = 0; k < DB + 2; k++) hist[k] = 0;
        m_code = 0; m_led = 0; m_changed = 0;
        sw = 4'd0; mode = 2'd0; rst = 1'b1;

        // Reset state
        step(0, 0, 1'b1);
        step(0, 0, 1'b1);
        chk("reset_led", int'(led), 0);
        chk("reset_code", int'(code), 0);
        chk("reset_changed", int'(changed), 0);

        // First edge after reset loads f(0, mode 0) without a strobe
        step(0, 0, 1'b0);
        chk("post_reset_led", int'(led), 32'h0001);
        chk("post_reset_changed", int'(changed), 0);

        // 1. Basic acceptance: 5 first sampled at edge 1, accepted at edge 7
        for (int e = 1; e <= 9; e++) begin
            step(5, 0, 1'b0);
            chk("t1_code", int'(code), (e >= 7) ? 5 : 0);
            chk("t1_changed", int'(changed), (e == 7) ? 1 : 0);
            chk("t1_led", int'(led), (e >= 7) ? 32'h0020 : 32'h0001);
        end

        // 2. Glitch rejection: 9 for three cycles, then back to 5
        for (int e = 0; e < 11; e++) begin
            step((e < 3) ? 9 : 5, 0, 1'b0);
            chk("t2_code", int'(code), 5);
            chk("t2_led", int'(led), 32'h0020);
            chk("t2_changed", int'(changed), 0);
        end

        // 3/4. Mode sweep and boundary codes from the vector table
        for (int i = 0; i < 8; i++) begin
            pulses = 0;
            same = (tbl[i].sw_v == m_code);
            step(tbl[i].sw_v, tbl[i].mode_v, 1'b0);
            pulses += int'(changed);
            if (same) chk("tbl_one_edge_led", int'(led), tbl[i].exp_led);
            for (int j = 1; j < 8; j++) begin
                step(tbl[i].sw_v, tbl[i].mode_v, 1'b0);
                pulses += int'(changed);
            end
            chk("tbl_code", int'(code), tbl[i].sw_v);
            chk("tbl_led", int'(led), tbl[i].exp_led);
            chk("tbl_pulses", pulses, tbl[i].exp_pulses);
        end

        // 5. Reset mid-debounce with 12 held
        for (int e = 1; e <= 3; e++) step(12, 0, 1'b0);
        step(12, 0, 1'b1);
        chk("t5_rst_code", int'(code), 0);
        chk("t5_rst_led", int'(led), 0);
        chk("t5_rst_changed", int'(changed), 0);
        for (int e = 1; e <= 8; e++) begin
            step(12, 0, 1'b0);
            chk("t5_code", int'(code), (e >= 7) ? 12 : 0);
            chk("t5_changed", int'(changed), (e == 7) ? 1 : 0);
        end

        // 6. Bounce train 3/4 every two cycles, then 4 held
        pulses = 0;
        pulse_at = -1;
        for (int i = 0; i < 32; i++) begin
            step((i < 20 && ((i / 2) % 2 == 0)) ? 3 : 4, 0, 1'b0);
            if (changed) begin
                pulses++;
                pulse_at = i;
            end
        end
        chk("t6_pulses", pulses, 1);
        chk("t6_pulse_edge", pulse_at, 24);
        chk("t6_code", int'(code), 4);
        chk("t6_led", int'(led), 32'h0010);

        // Randomised bursts against the model, with occasional resets
        for (int i = 0; i < 80; i++) begin
            v    = $urandom_range(0, 15);
            hold = $urandom_range(1, 9);
            m    = $urandom_range(0, 3);
            for (int j = 0; j < hold; j++)
                step(v, m, ($urandom_range(0, 59) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
